// File: rtl/poly_piano_voicer_if.sv
// poly_piano_voicer_if
//   Pad-side bundle of the polyphonic piano voicer.
//   i_ena            design enable (low forces every output to 0)
//   i_keys[11:0]     level-sensitive keys, bit i = note i (0=C .. 11=B)
//   i_octave[2:0]    octave shift, applied when a voice is allocated
//   o_audio_pdm      1-bit sigma-delta audio
//   o_level[VW-1:0]  number of voice tones currently high
//   o_active_voices  bit v = voice v is not idle
//   o_overflow       sticky: a key press found no voice to play on
interface poly_piano_voicer_if #(
   parameter int NUM_VOICES = 4
);
   localparam int VW = $clog2(NUM_VOICES + 1);

   logic                  i_ena;
   logic [11:0]           i_keys;
   logic [2:0]            i_octave;
   logic                  o_audio_pdm;
   logic [VW-1:0]         o_level;
   logic [NUM_VOICES-1:0] o_active_voices;
   logic                  o_overflow;

   modport master (
      output i_ena, i_keys, i_octave,
      input  o_audio_pdm, o_level, o_active_voices, o_overflow
   );

   modport slave (
      input  i_ena, i_keys, i_octave,
      output o_audio_pdm, o_level, o_active_voices, o_overflow
   );
endinterface

// File: rtl/poly_piano_voicer.sv
// poly_piano_voicer
//   12 piano keys plus an octave select drive NUM_VOICES square-wave voices.
//   A scan pointer visits one key per cycle and allocates / releases /
//   retriggers voices; the voice tones are summed into a level and turned
//   into a 1-bit audio stream by a first-order sigma-delta.
//   clk   system clock (divider table assumes 10 MHz)
//   rst   synchronous active-high reset
//   bus   poly_piano_voicer_if.slave (keys, octave, enable in; audio, level,
//         active voices, overflow out)
//
//   voice state | meaning
//   ------------+-----------------------------------------------------
//   V_IDLE      | free, silent, cnt/tone held at 0
//   V_ON        | key held, tone running
//   V_REL       | key released, tone running, release timer counting down
module poly_piano_voicer #(
   parameter int NUM_VOICES     = 4,
   parameter int WIDTH_COUNTER  = 16,
   parameter int RELEASE_CYCLES = 65535
) (
   input  logic               clk,
   input  logic               rst,
   poly_piano_voicer_if.slave bus
);
   localparam int VW = $clog2(NUM_VOICES + 1);
   localparam int AW = VW + 1;
   localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
   localparam logic [RW-1:0] REL_LOAD = RW'(RELEASE_CYCLES - 1);

   typedef enum logic [1:0] {
      V_IDLE = 2'd0,
      V_ON   = 2'd1,
      V_REL  = 2'd2
   } voice_state_t;

   // C3..B3 half-periods in 10 MHz clocks
   function automatic logic [15:0] f_note_div(input logic [3:0] i_k);
      logic [15:0] w_d;
      case (i_k)
         4'd0:    w_d = 16'd38223;
         4'd1:    w_d = 16'd36077;
         4'd2:    w_d = 16'd34052;
         4'd3:    w_d = 16'd32141;
         4'd4:    w_d = 16'd30337;
         4'd5:    w_d = 16'd28635;
         4'd6:    w_d = 16'd27027;
         4'd7:    w_d = 16'd25511;
         4'd8:    w_d = 16'd24079;
         4'd9:    w_d = 16'd22727;
         4'd10:   w_d = 16'd21452;
         default: w_d = 16'd20248;
      endcase
      return w_d;
   endfunction

   logic [11:0]              r_keys_q;
   logic [3:0]               r_ptr;
   voice_state_t             r_state [NUM_VOICES];
   logic [3:0]               r_key   [NUM_VOICES];
   logic [WIDTH_COUNTER-1:0] r_div   [NUM_VOICES];
   logic [WIDTH_COUNTER-1:0] r_cnt   [NUM_VOICES];
   logic [RW-1:0]            r_rel   [NUM_VOICES];
   logic [NUM_VOICES-1:0]    r_tone;
   logic [VW-1:0]            r_level;
   logic [VW-1:0]            r_acc;
   logic                     r_pdm;
   logic                     r_overflow;

   voice_state_t             w_state_nxt [NUM_VOICES];
   logic [3:0]               w_key_nxt   [NUM_VOICES];
   logic [WIDTH_COUNTER-1:0] w_div_nxt   [NUM_VOICES];
   logic [WIDTH_COUNTER-1:0] w_cnt_nxt   [NUM_VOICES];
   logic [WIDTH_COUNTER-1:0] w_run_cnt   [NUM_VOICES];
   logic [RW-1:0]            w_rel_nxt   [NUM_VOICES];
   logic [NUM_VOICES-1:0]    w_tone_nxt;
   logic [NUM_VOICES-1:0]    w_run_tone;
   logic [NUM_VOICES-1:0]    w_tc;
   logic [NUM_VOICES-1:0]    w_active;
   logic [NUM_VOICES-1:0]    w_on_mask;
   logic [NUM_VOICES-1:0]    w_rel_mask;
   logic [NUM_VOICES-1:0]    w_hit_oh;
   logic [NUM_VOICES-1:0]    w_idle_oh;
   logic [NUM_VOICES-1:0]    w_rel_oh;
   logic [NUM_VOICES-1:0]    w_alloc_oh;
   logic [NUM_VOICES-1:0]    w_retrig_oh;
   logic [NUM_VOICES-1:0]    w_release_oh;
   logic                     w_idle_any;
   logic                     w_rel_any;
   logic                     w_key_on;
   logic                     w_drop;
   logic [WIDTH_COUNTER-1:0] w_new_div;
   logic [VW-1:0]            w_pop;
   logic [AW-1:0]            w_sum;
   logic [VW-1:0]            w_acc_nxt;
   logic                     w_pdm_nxt;

   // scan decision and per-voice next state
   always_comb begin
      w_key_on     = r_keys_q[r_ptr];
      w_new_div    = WIDTH_COUNTER'(f_note_div(r_ptr) >> bus.i_octave);
      w_hit_oh     = '0;
      w_idle_oh    = '0;
      w_rel_oh     = '0;
      w_on_mask    = '0;
      w_rel_mask   = '0;
      w_active     = '0;
      w_idle_any   = 1'b0;
      w_rel_any    = 1'b0;
      w_alloc_oh   = '0;
      w_retrig_oh  = '0;
      w_release_oh = '0;
      w_drop       = 1'b0;

      for (int v = 0; v < NUM_VOICES; v++) begin
         w_active[v]   = (r_state[v] != V_IDLE);
         w_on_mask[v]  = (r_state[v] == V_ON);
         w_rel_mask[v] = (r_state[v] == V_REL);
         if (w_active[v] && (r_key[v] == r_ptr)) w_hit_oh[v] = 1'b1;
         // first match wins, giving lowest-index priority
         if ((r_state[v] == V_IDLE) && !w_idle_any) begin
            w_idle_oh[v] = 1'b1;
            w_idle_any   = 1'b1;
         end
         if ((r_state[v] == V_REL) && !w_rel_any) begin
            w_rel_oh[v] = 1'b1;
            w_rel_any   = 1'b1;
         end
      end

      if (w_key_on) begin
         if (w_hit_oh == '0) begin
            if (w_idle_any)     w_alloc_oh = w_idle_oh;
            else if (w_rel_any) w_alloc_oh = w_rel_oh;
            else                w_drop     = 1'b1;
         end else begin
            w_retrig_oh = w_hit_oh & w_rel_mask;
         end
      end else begin
         w_release_oh = w_hit_oh & w_on_mask;
      end

      for (int v = 0; v < NUM_VOICES; v++) begin
         // dividers of 0 or 1 both mean toggle every cycle
         w_tc[v]       = (r_div[v] <= WIDTH_COUNTER'(1)) ||
                         (r_cnt[v] == r_div[v] - WIDTH_COUNTER'(1));
         w_run_cnt[v]  = w_tc[v] ? '0 : r_cnt[v] + WIDTH_COUNTER'(1);
         w_run_tone[v] = r_tone[v] ^ w_tc[v];

         w_state_nxt[v] = r_state[v];
         w_key_nxt[v]   = r_key[v];
         w_div_nxt[v]   = r_div[v];
         w_rel_nxt[v]   = r_rel[v];
         w_cnt_nxt[v]   = w_run_cnt[v];
         w_tone_nxt[v]  = w_run_tone[v];

         case (r_state[v])
            V_IDLE: begin
               w_cnt_nxt[v]  = '0;
               w_tone_nxt[v] = 1'b0;
            end
            V_REL: begin
               if (r_rel[v] == '0) begin
                  w_state_nxt[v] = V_IDLE;
                  w_cnt_nxt[v]   = '0;
                  w_tone_nxt[v]  = 1'b0;
               end else begin
                  w_rel_nxt[v] = r_rel[v] - RW'(1);
               end
            end
            default: ;
         endcase

         // the scan decision overrides the voice's own progression,
         // so a retrigger on the last release cycle keeps the tone phase
         if (w_alloc_oh[v]) begin
            w_state_nxt[v] = V_ON;
            w_key_nxt[v]   = r_ptr;
            w_div_nxt[v]   = w_new_div;
            w_cnt_nxt[v]   = '0;
            w_tone_nxt[v]  = 1'b0;
         end else if (w_retrig_oh[v]) begin
            w_state_nxt[v] = V_ON;
            w_cnt_nxt[v]   = w_run_cnt[v];
            w_tone_nxt[v]  = w_run_tone[v];
         end else if (w_release_oh[v]) begin
            w_state_nxt[v] = V_REL;
            w_rel_nxt[v]   = REL_LOAD;
         end
      end
   end

   // mixer and first-order sigma-delta
   always_comb begin
      w_pop = '0;
      for (int v = 0; v < NUM_VOICES; v++) w_pop = w_pop + VW'(r_tone[v]);
      w_sum     = AW'(r_acc) + AW'(r_level);
      w_pdm_nxt = 1'b0;
      w_acc_nxt = VW'(w_sum);
      if (w_sum >= AW'(NUM_VOICES)) begin
         w_pdm_nxt = 1'b1;
         w_acc_nxt = VW'(w_sum - AW'(NUM_VOICES));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_keys_q   <= '0;
         r_ptr      <= '0;
         r_tone     <= '0;
         r_level    <= '0;
         r_acc      <= '0;
         r_pdm      <= 1'b0;
         r_overflow <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_state[v] <= V_IDLE;
            r_key[v]   <= '0;
            r_div[v]   <= '0;
            r_cnt[v]   <= '0;
            r_rel[v]   <= '0;
         end
      end else begin
         r_keys_q <= bus.i_keys;
         r_ptr    <= (r_ptr == 4'd11) ? 4'd0 : r_ptr + 4'd1;
         r_tone   <= w_tone_nxt;
         r_level  <= w_pop;
         r_acc    <= w_acc_nxt;
         r_pdm    <= w_pdm_nxt;
         if (w_drop) r_overflow <= 1'b1;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_state[v] <= w_state_nxt[v];
            r_key[v]   <= w_key_nxt[v];
            r_div[v]   <= w_div_nxt[v];
            r_cnt[v]   <= w_cnt_nxt[v];
            r_rel[v]   <= w_rel_nxt[v];
         end
      end
   end

   // enable gates the pins only; the voices keep running underneath
   assign bus.o_audio_pdm     = bus.i_ena & r_pdm;
   assign bus.o_level         = bus.i_ena ? r_level : '0;
   assign bus.o_active_voices = bus.i_ena ? w_active : '0;
   assign bus.o_overflow      = bus.i_ena & r_overflow;

endmodule

// File: tb/tb_poly_piano_voicer.sv
// tb_poly_piano_voicer
//   Directed scenarios plus a randomized phase, every cycle compared
//   against a voice-level reference model: each voice is a record of
//   {state, key, divider, age since allocation, release cycles left}, and
//   its tone is derived as (age / divider) mod 2.
module tb_poly_piano_voicer;
   localparam int NV = 4;
   localparam int WC = 16;
   localparam int RC = 100;
   localparam int VW = $clog2(NV + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   poly_piano_voicer_if #(.NUM_VOICES(NV)) bus ();

   poly_piano_voicer #(
      .NUM_VOICES    (NV),
      .WIDTH_COUNTER (WC),
      .RELEASE_CYCLES(RC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   const int note_div [12] = '{38223, 36077, 34052, 32141, 30337, 28635,
                               27027, 25511, 24079, 22727, 21452, 20248};

   // model: state 0=idle 1=on 2=release
   int m_st  [NV];
   int m_key [NV];
   int m_div [NV];
   int m_age [NV];
   int m_rel [NV];
   int m_kq, m_p, m_lvl, m_acc, m_pdm, m_ovf;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int m_tone(input int v);
      int d;
      if (m_st[v] == 0) return 0;
      d = (m_div[v] < 2) ? 1 : m_div[v];
      return (m_age[v] / d) % 2;
   endfunction

   task automatic model_step();
      int act [NV];
      int hold, tgt, pre_pop, s;
      if (rst) begin
         for (int v = 0; v < NV; v++) begin
            m_st[v] = 0; m_key[v] = 0; m_div[v] = 0; m_age[v] = 0; m_rel[v] = 0;
         end
         m_kq = 0; m_p = 0; m_lvl = 0; m_acc = 0; m_pdm = 0; m_ovf = 0;
         return;
      end
      pre_pop = 0;
      hold = -1;
      for (int v = 0; v < NV; v++) begin
         pre_pop += m_tone(v);
         act[v] = 0;
         if (m_st[v] != 0 && m_key[v] == m_p) hold = v;
      end
      if (((m_kq >> m_p) & 1) == 1) begin
         if (hold >= 0) begin
            if (m_st[hold] == 2) act[hold] = 2;
         end else begin
            tgt = -1;
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] == 0) tgt = v;
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_st[v] == 2) tgt = v;
            if (tgt < 0) m_ovf = 1;
            else act[tgt] = 1;
         end
      end else if (hold >= 0 && m_st[hold] == 1) begin
         act[hold] = 3;
      end
      for (int v = 0; v < NV; v++) begin
         case (act[v])
            1: begin
               m_st[v] = 1; m_key[v] = m_p;
               m_div[v] = (note_div[m_p] >> int'(bus.i_octave)) & 16'hffff;
               m_age[v] = 0;
            end
            2: begin m_st[v] = 1; m_age[v]++; end
            3: begin m_st[v] = 2; m_rel[v] = RC - 1; m_age[v]++; end
            default: begin
               if (m_st[v] == 1) m_age[v]++;
               else if (m_st[v] == 2) begin
                  if (m_rel[v] == 0) begin m_st[v] = 0; m_age[v] = 0; end
                  else begin m_rel[v]--; m_age[v]++; end
               end
            end
         endcase
      end
      s = m_acc + m_lvl;
      if (s >= NV) begin m_pdm = 1; m_acc = s - NV; end
      else begin m_pdm = 0; m_acc = s; end
      m_lvl = pre_pop;
      m_kq  = int'(bus.i_keys);
      m_p   = (m_p + 1) % 12;
   endtask

   function automatic logic [31:0] model_outs();
      int mask = 0;
      if (!bus.i_ena) return 0;
      for (int v = 0; v < NV; v++) if (m_st[v] != 0) mask |= (1 << v);
      return 32'((m_pdm << (VW + NV + 1)) | (m_lvl << (NV + 1)) | (mask << 1) | m_ovf);
   endfunction

   function automatic logic [31:0] dut_outs();
      return 32'({bus.o_audio_pdm, bus.o_level, bus.o_active_voices, bus.o_overflow});
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_eq("outs", dut_outs(), model_outs());
   endtask

   task automatic wait_active(input logic [NV-1:0] exp, input int budget, output int n);
      n = 0;
      while (bus.o_active_voices !== exp && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      wait_active('0, 300, n);
      check_eq(tag, 32'(bus.o_active_voices), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, s, t, t_rel;
      rst = 1'b1;
      bus.i_ena = 1'b1;
      bus.i_keys = '0;
      bus.i_octave = '0;
      tick(); tick();
      check_eq("rst_outs", dut_outs(), 32'd0);
      rst = 1'b0;
      tick();

      // single C3, octave 0
      bus.i_keys = 12'h001;
      wait_active(4'b0001, 20, n);
      check_eq("t1_active", 32'(bus.o_active_voices), 32'd1);
      check_eq("t1_latency", 32'(n <= 13), 32'd1);
      n = 0;
      while (bus.o_level !== 3'd1 && n < 40000) begin tick(); n++; end
      check_eq("t1_half_period", 32'(n), 32'd38224);
      tick();
      s = 0;
      repeat (4) begin tick(); s += int'(bus.o_audio_pdm); end
      check_eq("t1_pdm_density", 32'(s), 32'd1);
      bus.i_keys = '0;
      wait_idle("t1_idle");

      // octave 2, octave change mid-note must not retune
      bus.i_octave = 3'd2;
      bus.i_keys = 12'h001;
      wait_active(4'b0001, 20, n);
      check_eq("t2_active", 32'(bus.o_active_voices), 32'd1);
      bus.i_octave = 3'd0;
      n = 0;
      while (bus.o_level !== 3'd1 && n < 12000) begin tick(); n++; end
      check_eq("t2_half_period", 32'(n), 32'd9556);
      bus.i_keys = '0;
      wait_idle("t2_idle");

      // release window length and retrigger
      bus.i_octave = 3'd7;
      bus.i_keys = 12'h001;
      wait_active(4'b0001, 20, n);
      repeat (5) tick();
      bus.i_keys = '0;
      t = 0; t_rel = -1;
      while (bus.o_active_voices[0] !== 1'b0 && t < 300) begin
         tick(); t++;
         if (t_rel < 0 && m_st[0] == 2) t_rel = t;
      end
      check_eq("t4_release_len", 32'(t - t_rel), 32'd100);
      bus.i_keys = 12'h001;
      wait_active(4'b0001, 20, n);
      bus.i_keys = '0;
      n = 0;
      while (m_st[0] != 2 && n < 20) begin tick(); n++; end
      repeat (30) tick();
      bus.i_keys = 12'h001;
      repeat (150) tick();
      check_eq("t4_retrigger", 32'(bus.o_active_voices), 32'd1);
      bus.i_keys = '0;
      wait_idle("t4_idle");

      // steal the lowest released voice
      bus.i_keys = 12'h00f;
      repeat (14) tick();
      check_eq("t5_four_on", 32'(bus.o_active_voices), 32'hf);
      bus.i_keys = '0;
      repeat (14) tick();
      bus.i_keys = 12'h020;
      repeat (14) tick();
      check_eq("t5_all_busy", 32'(bus.o_active_voices), 32'hf);
      repeat (110) tick();
      check_eq("t5_steal_v0", 32'(bus.o_active_voices), 32'd1);
      bus.i_keys = '0;
      wait_idle("t5_idle");

      // five keys on four voices
      bus.i_keys = 12'h895;
      repeat (14) tick();
      check_eq("t3_four_on", 32'(bus.o_active_voices), 32'hf);
      check_eq("t3_overflow", 32'(bus.o_overflow), 32'd1);
      bus.i_keys = '0;
      wait_idle("t3_idle");
      check_eq("t3_overflow_sticky", 32'(bus.o_overflow), 32'd1);

      // reset mid-note, then enable gating
      bus.i_keys = 12'h091;
      repeat (14) tick();
      check_eq("t6_three_on", 32'(bus.o_active_voices), 32'h7);
      rst = 1'b1;
      tick();
      check_eq("t6_rst_outs", dut_outs(), 32'd0);
      rst = 1'b0;
      repeat (14) tick();
      check_eq("t6_realloc", 32'(bus.o_active_voices), 32'h7);
      bus.i_ena = 1'b0;
      tick();
      check_eq("t6_ena_off", dut_outs(), 32'd0);
      repeat (5) tick();
      bus.i_ena = 1'b1;
      tick();
      check_eq("t6_ena_on", 32'(bus.o_active_voices), 32'h7);

      // randomized key traffic
      for (int i = 0; i < 150; i++) begin
         bus.i_keys   = 12'($urandom & $urandom);
         bus.i_octave = 3'($urandom_range(7, 4));
         bus.i_ena    = ($urandom_range(0, 9) != 0);
         repeat ($urandom_range(5, 40)) tick();
      end
      bus.i_ena = 1'b1;
      bus.i_keys = '0;
      wait_idle("rand_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
